sized_data_memory: RTL and testbench
====================================

// Module: sized_data_memory
// PURPOSE
//  Word-organised data memory with byte/half/word access, sign/zero-extended loads,
//  a valid/ready request port and a programmable response latency. A hardware
//  sweeper clears the array after reset. Sits between the core's MEM stage and the
//  datapath; it lets later labs model slow memory and exercise stall logic.
// PARAMETERS
//  MEM_DEPTH       16384  number of 32-bit words; power of 2, >= 4
//  LATENCY         1      cycles from request accept to resp_valid; >= 1
//  CLEAR_ON_RESET  1      1: zero the array after reset (INIT sweep); 0: skip INIT
// PORTS
//  clk           in   1   clock, all state updates on posedge
//  reset         in   1   asynchronous, active-high reset
//  req_valid     in   1   request present
//  req_ready     out  1   memory accepts request this cycle
//  req_write     in   1   1 = store, 0 = load
//  req_addr      in   32  byte address
//  req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1   load: 1 zero-extend, 0 sign-extend (ignored for word/stores)
//  req_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid    out  1   one-cycle pulse: response for the accepted request
//  resp_rdata    out  32  extended load data; 0 for stores and errors
//  resp_err      out  1   misaligned or illegal-size request (with resp_valid)
//  init_busy     out  1   INIT sweep in progress
// BEHAVIOUR
//  - Word index = req_addr[AW+1:2], AW = $clog2(MEM_DEPTH); upper bits ignored
//    (aliasing/wrap, no error). Lane = req_addr[1:0].
//  - Reset (async): req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0,
//    init_busy=CLEAR_ON_RESET, state=INIT (or IDLE if CLEAR_ON_RESET=0).
//    Array is not reset asynchronously; it is cleared by the sweep.
//  - FSM INIT: one word zeroed per cycle, index 0..MEM_DEPTH-1; exactly MEM_DEPTH
//    cycles after reset release -> IDLE, init_busy falls with the transition.
//    Reset during INIT restarts the sweep at 0.
//  - IDLE: req_ready=1. Accept = req_valid & req_ready at posedge -> WAIT,
//    latency counter loaded with LATENCY-1. Request is registered at accept.
//  - Store commits to the array at the accept edge, byte-enabled: byte writes lane
//    addr[1:0], half writes lanes {addr[1],0}+{0,1}, word writes all four.
//    Other lanes are unchanged.
//  - Load data is read at the accept edge, extracted from the addressed lane(s),
//    extended per req_unsigned and held in resp_rdata until the next response.
//  - WAIT: req_ready=0; counter decrements each cycle. When counter==0 resp_valid=1
//    for exactly that cycle, then -> IDLE. Response cycle = accept edge + LATENCY.
//    One outstanding request max; throughput 1 per LATENCY+1 cycles.
//  - Error: size 11, half with addr[0]=1, word with addr[1:0]!=0 -> no array write,
//    resp_err=1, resp_rdata=0, same latency as a good request.
//  - resp_rdata/resp_err registered; they change only at a response, hold otherwise.
//  - Reset mid-WAIT: response dropped; a store accepted before reset stays committed
//    unless overwritten by a subsequent INIT sweep.
//  - req_valid while req_ready=0 is ignored (no queuing); requester must hold it.
// STRUCTURE
//  - Package dmem_pkg: size encodings SZ_B/SZ_H/SZ_W/SZ_BAD, FSM state enum
//    {INIT, IDLE, WAIT}, misalignment-check function.
//  - Sub-module lsu_align (combinational): size+lane+wdata -> 4-bit byte enable,
//    lane-replicated write word, error flag; read word -> extended load data.
//  - Top: FSM, sweep counter, latency counter, array with byte-enable write port.
// TESTING (MEM_DEPTH=16 unless noted)
//  - Reset release: init_busy high 16 cycles, req_ready rises cycle 16; then load
//    word from 0x3C -> resp_rdata=0x00000000, resp_err=0.
//  - SW 0x11223344 @0x8; LB @0x9 -> 0x00000033; LB @0xB -> 0x00000011; SB 0xF0 @0xA;
//    LW @0x8 -> 0x11F03344; LB signed @0xA -> 0xFFFFFFF0, LBU -> 0x000000F0.
//  - SH 0x8001 @0x6; LH @0x6 -> 0xFFFF8001; LHU -> 0x00008001; LW @0x4 lanes 0-1 unchanged.
//  - Misaligned: LW @0x2, SH @0x5, size 11 -> resp_err=1, rdata=0; following LW shows no write.
//  - LATENCY=3: accept at edge N -> resp_valid only at cycle N+3, req_ready low N+1..N+3;
//    held req_valid accepted at N+4.
//  - Async reset asserted mid-WAIT: resp_valid, req_ready drop immediately, no response
//    pulse; re-sweep completes; address alias @0x40 reads same word as @0x0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data memory: access sizes, controller states and
// the alignment rule that decides whether a request is rejected.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_BAD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      INIT = 2'b00,
      IDLE = 2'b01,
      WAIT = 2'b10
   } state_e;

   // A request is rejected for an illegal size or a lane offset the size cannot start on.
   function automatic logic is_misaligned(input size_e sz, input logic [1:0] lane);
      logic bad;
      bad = 1'b0;
      case (sz)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = lane[0];
         SZ_W:    bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store size/lane/data to byte enables and a replicated
// write word, and the addressed word to a sign- or zero-extended load value.
module lsu_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic        err,
   output logic [31:0] rdata
);

   size_e       sz;
   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   assign sz    = size_e'(size);
   assign err   = is_misaligned(sz, lane);
   assign sel_b = 8'(rword >> {lane, 3'b000});
   assign sel_h = 16'(rword >> {lane[1], 4'b0000});

   // Rejected requests leave be and rdata at zero so nothing is written or returned.
   always_comb begin
      be    = 4'b0000;
      wword = 32'h0000_0000;
      rdata = 32'h0000_0000;
      if (!err) begin
         case (sz)
            SZ_B: begin
               be    = 4'b0001 << lane;
               wword = {4{wdata[7:0]}};
               rdata = is_unsigned ? {24'h00_0000, sel_b} : {{24{sel_b[7]}}, sel_b};
            end
            SZ_H: begin
               be    = lane[1] ? 4'b1100 : 4'b0011;
               wword = {2{wdata[15:0]}};
               rdata = is_unsigned ? {16'h0000, sel_h} : {{16{sel_h[15]}}, sel_h};
            end
            SZ_W: begin
               be    = 4'b1111;
               wword = wdata;
               rdata = rword;
            end
            default: begin
               be    = 4'b0000;
               wword = 32'h0000_0000;
               rdata = 32'h0000_0000;
            end
         endcase
      end
   end

endmodule

// File: rtl/sized_data_memory.sv
// Word-organised data memory with sized loads/stores, one outstanding request and a
// fixed response delay of LATENCY cycles; req_ready is low while a request is pending.
module sized_data_memory
   import dmem_pkg::*;
#(
   parameter int MEM_DEPTH      = 16384,
   parameter int LATENCY        = 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        init_busy
);

   localparam int             AW          = $clog2(MEM_DEPTH);
   localparam int             CW          = $clog2(LATENCY + 1);
   localparam logic [CW-1:0]  LAT_LOAD    = CW'(LATENCY - 1);
   localparam logic [AW-1:0]  LAST_IDX    = AW'(MEM_DEPTH - 1);
   localparam state_e         RESET_STATE = state_e'(CLEAR_ON_RESET ? INIT : IDLE);

   state_e        state_q, state_d;
   logic [AW-1:0] sweep_q, sweep_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          req_ready_q, req_ready_d;
   logic          resp_valid_q, resp_valid_d;
   logic [31:0]   resp_rdata_q, resp_rdata_d;
   logic          resp_err_q, resp_err_d;
   logic          init_busy_q, init_busy_d;
   logic [31:0]   pend_rdata_q, pend_rdata_d;
   logic          pend_err_q, pend_err_d;

   logic [31:0]   mem_q [MEM_DEPTH];

   logic [AW-1:0] word_idx;
   logic [31:0]   rword;
   logic [3:0]    be;
   logic [31:0]   wword;
   logic          align_err;
   logic [31:0]   load_data;
   logic          accept;
   logic          unused_addr_bits;

   // Address bits above the array size alias onto the same words.
   assign word_idx         = req_addr[AW+1:2];
   assign unused_addr_bits = ^req_addr[31:AW+2];
   assign rword            = mem_q[word_idx];
   assign accept           = req_valid & req_ready_q;

   lsu_align u_align (
      .size        (req_size),
      .lane        (req_addr[1:0]),
      .is_unsigned (req_unsigned),
      .wdata       (req_wdata),
      .rword       (rword),
      .be          (be),
      .wword       (wword),
      .err         (align_err),
      .rdata       (load_data)
   );

   always_comb begin
      state_d      = state_q;
      sweep_d      = sweep_q;
      cnt_d        = cnt_q;
      pend_rdata_d = pend_rdata_q;
      pend_err_d   = pend_err_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      case (state_q)
         INIT: begin
            if (sweep_q == LAST_IDX) begin
               state_d = IDLE;
               sweep_d = '0;
            end else begin
               sweep_d = sweep_q + 1'b1;
            end
         end
         IDLE: begin
            if (accept) begin
               state_d      = WAIT;
               cnt_d        = LAT_LOAD;
               pend_rdata_d = req_write ? 32'h0000_0000 : load_data;
               pend_err_d   = align_err;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // The response cycle is the one spent in WAIT with the counter at zero.
      resp_valid_d = (state_d == WAIT) && (cnt_d == '0);
      if (resp_valid_d) begin
         resp_rdata_d = pend_rdata_d;
         resp_err_d   = pend_err_d;
      end
      req_ready_d = (state_d == IDLE);
      init_busy_d = (state_d == INIT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= RESET_STATE;
         sweep_q      <= '0;
         cnt_q        <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
         resp_err_q   <= 1'b0;
         init_busy_q  <= CLEAR_ON_RESET;
         pend_rdata_q <= 32'h0000_0000;
         pend_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sweep_q      <= sweep_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         init_busy_q  <= init_busy_d;
         pend_rdata_q <= pend_rdata_d;
         pend_err_q   <= pend_err_d;
      end
   end

   // Storage has no reset; the sweep zeroes it one word per cycle instead.
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         mem_q[sweep_q] <= 32'h0000_0000;
      end else if (accept && req_write) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem_q[word_idx][8*i +: 8] <= wword[8*i +: 8];
            end
         end
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign init_busy  = init_busy_q;

endmodule

// File: tb/tb_sized_data_memory.sv
// Bench for sized_data_memory: two instances (LATENCY 1 and 3, depth 16) driven by
// directed and random requests, checked against a byte-array reference model.
module tb_sized_data_memory;

   logic        clk;
   logic        reset;
   logic        req_valid1, req_valid3;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        ready1, ready3, rv1, rv3, err1, err3, busy1, busy3;
   logic [31:0] rdata1, rdata3;

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0]  mdl [2][64];
   logic [1:0]  rdy_v, rv_v, err_v, busy_v;
   logic [31:0] rdata_v [2];

   always_comb begin
      rdy_v      = {ready3, ready1};
      rv_v       = {rv3, rv1};
      err_v      = {err3, err1};
      busy_v     = {busy3, busy1};
      rdata_v[0] = rdata1;
      rdata_v[1] = rdata3;
   end

   sized_data_memory #(.MEM_DEPTH(16), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(ready1),
      .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(rv1),
      .resp_rdata(rdata1), .resp_err(err1), .init_busy(busy1));

   sized_data_memory #(.MEM_DEPTH(16), .LATENCY(3), .CLEAR_ON_RESET(1'b1)) dut3 (
      .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(ready3),
      .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_wdata(req_wdata), .resp_valid(rv3),
      .resp_rdata(rdata3), .resp_err(err3), .init_busy(busy3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_model();
      for (int s = 0; s < 2; s++)
         for (int b = 0; b < 64; b++)
            mdl[s][b] = 8'h00;
   endtask

   // Reference: memory as 64 bytes per instance, addresses wrap modulo 64.
   task automatic model_access(input int sel, input bit wr, input logic [31:0] addr,
                               input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                               output logic [31:0] r, output logic e);
      int nbytes;
      int base;
      logic [31:0] v;
      nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      e      = (size == 2'd3) || ((addr % nbytes) != 0);
      base   = int'(addr % 64);
      r      = 32'h0;
      if (!e) begin
         if (wr) begin
            for (int i = 0; i < nbytes; i++) mdl[sel][base + i] = wdata[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < nbytes; i++) v = v | (32'(mdl[sel][base + i]) << (8 * i));
            if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
            r = v;
         end
      end
   endtask

   task automatic do_req(input int sel, input bit wr, input logic [31:0] addr,
                         input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                         input string name, output logic [31:0] got_rdata, output logic got_err);
      int lat;
      int n;
      logic [31:0] exp_r;
      logic exp_e;
      lat = (sel == 1) ? 3 : 1;
      got_rdata = 32'hx;
      got_err = 1'bx;
      n = 0;
      @(negedge clk);
      while (rdy_v[sel] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (rdy_v[sel] !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s ready_timeout: got %b want 1", name, rdy_v[sel]);
         return;
      end
      req_write = wr; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
      if (sel == 1) req_valid3 = 1'b1; else req_valid1 = 1'b1;
      model_access(sel, wr, addr, size, uns, wdata, exp_r, exp_e);
      @(posedge clk);
      #1;
      req_valid1 = 1'b0;
      req_valid3 = 1'b0;
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         if (k < lat) begin
            tests_run++;
            if (rv_v[sel] !== 1'b0 || rdy_v[sel] !== 1'b0) begin
               tests_failed++;
               $display("FAIL %s early_k%0d: valid/ready got %b%b want 00", name, k, rv_v[sel], rdy_v[sel]);
            end
         end else if (k == lat) begin
            got_rdata = rdata_v[sel];
            got_err = err_v[sel];
            tests_run++;
            if (rv_v[sel] !== 1'b1 || rdy_v[sel] !== 1'b0) begin
               tests_failed++;
               $display("FAIL %s resp_pulse: valid/ready got %b%b want 10", name, rv_v[sel], rdy_v[sel]);
            end
            tests_run++;
            if (rdata_v[sel] !== exp_r || err_v[sel] !== exp_e) begin
               tests_failed++;
               $display("FAIL %s resp_data: got %h err %b want %h err %b", name, rdata_v[sel], err_v[sel], exp_r, exp_e);
            end
         end else begin
            tests_run++;
            if (rv_v[sel] !== 1'b0 || rdy_v[sel] !== 1'b1 || rdata_v[sel] !== exp_r) begin
               tests_failed++;
               $display("FAIL %s after_resp: valid %b ready %b rdata %h want 0 1 %h", name, rv_v[sel], rdy_v[sel], rdata_v[sel], exp_r);
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] r;
      logic e;
      reset = 1'b1;
      req_valid1 = 1'b0; req_valid3 = 1'b0;
      req_write = 1'b0; req_addr = 32'h0; req_size = 2'd2; req_unsigned = 1'b0; req_wdata = 32'h0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         tests_run++;
         if (rdy_v[s] !== 1'b0 || rv_v[s] !== 1'b0 || rdata_v[s] !== 32'h0 || err_v[s] !== 1'b0 || busy_v[s] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state_%0d: rdy %b rv %b rdata %h err %b busy %b want 0 0 0 0 1",
                     s, rdy_v[s], rv_v[s], rdata_v[s], err_v[s], busy_v[s]);
         end
      end
      // Interrupt the sweep partway; the counted window below must restart from zero.
      reset = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         tests_run++;
         if (busy1 !== (k < 16) || busy3 !== (k < 16) || ready1 !== (k == 16) || ready3 !== (k == 16)) begin
            tests_failed++;
            $display("FAIL init_sweep_c%0d: busy %b%b ready %b%b want busy %b ready %b",
                     k, busy3, busy1, ready3, ready1, (k < 16), (k == 16));
         end
      end
      clear_model();
      do_req(0, 1'b0, 32'h3C, 2'd2, 1'b0, 32'h0, "lw_3c_after_init", r, e);
      tests_run++;
      if (r !== 32'h0 || e !== 1'b0) begin
         tests_failed++;
         $display("FAIL lw_3c_const: got %h err %b want 00000000 err 0", r, e);
      end
   endtask

   task automatic test_byte_word();
      logic [31:0] r;
      logic e;
      do_req(0, 1'b1, 32'h8, 2'd2, 1'b0, 32'h11223344, "sw_8", r, e);
      do_req(0, 1'b0, 32'h9, 2'd0, 1'b0, 32'h0, "lb_9", r, e);
      tests_run++;
      if (r !== 32'h00000033) begin tests_failed++; $display("FAIL lb_9_const: got %h want 00000033", r); end
      do_req(0, 1'b0, 32'hB, 2'd0, 1'b0, 32'h0, "lb_b", r, e);
      tests_run++;
      if (r !== 32'h00000011) begin tests_failed++; $display("FAIL lb_b_const: got %h want 00000011", r); end
      do_req(0, 1'b1, 32'hA, 2'd0, 1'b0, 32'h000000F0, "sb_a", r, e);
      do_req(0, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, "lw_8", r, e);
      tests_run++;
      if (r !== 32'h11F03344) begin tests_failed++; $display("FAIL lw_8_const: got %h want 11f03344", r); end
      do_req(0, 1'b0, 32'hA, 2'd0, 1'b0, 32'h0, "lb_a", r, e);
      tests_run++;
      if (r !== 32'hFFFFFFF0) begin tests_failed++; $display("FAIL lb_a_const: got %h want fffffff0", r); end
      do_req(0, 1'b0, 32'hA, 2'd0, 1'b1, 32'h0, "lbu_a", r, e);
      tests_run++;
      if (r !== 32'h000000F0) begin tests_failed++; $display("FAIL lbu_a_const: got %h want 000000f0", r); end
   endtask

   task automatic test_half();
      logic [31:0] r;
      logic e;
      do_req(0, 1'b1, 32'h6, 2'd1, 1'b0, 32'hABCD8001, "sh_6", r, e);
      do_req(0, 1'b0, 32'h6, 2'd1, 1'b0, 32'h0, "lh_6", r, e);
      tests_run++;
      if (r !== 32'hFFFF8001) begin tests_failed++; $display("FAIL lh_6_const: got %h want ffff8001", r); end
      do_req(0, 1'b0, 32'h6, 2'd1, 1'b1, 32'h0, "lhu_6", r, e);
      tests_run++;
      if (r !== 32'h00008001) begin tests_failed++; $display("FAIL lhu_6_const: got %h want 00008001", r); end
      do_req(0, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, "lw_4", r, e);
      tests_run++;
      if (r !== 32'h80010000) begin tests_failed++; $display("FAIL lw_4_const: got %h want 80010000", r); end
   endtask

   task automatic test_misaligned();
      logic [31:0] r;
      logic e;
      do_req(0, 1'b0, 32'h2, 2'd2, 1'b0, 32'h0, "lw_2_mis", r, e);
      tests_run++;
      if (e !== 1'b1 || r !== 32'h0) begin tests_failed++; $display("FAIL lw_2_err: got %h err %b want 0 err 1", r, e); end
      do_req(0, 1'b1, 32'h5, 2'd1, 1'b0, 32'h0000BEEF, "sh_5_mis", r, e);
      tests_run++;
      if (e !== 1'b1) begin tests_failed++; $display("FAIL sh_5_err: got err %b want 1", e); end
      do_req(0, 1'b1, 32'h10, 2'd3, 1'b0, 32'hDEADBEEF, "sz3_store", r, e);
      tests_run++;
      if (e !== 1'b1) begin tests_failed++; $display("FAIL sz3_err: got err %b want 1", e); end
      do_req(0, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, "lw_4_nowrite", r, e);
      tests_run++;
      if (r !== 32'h80010000 || e !== 1'b0) begin tests_failed++; $display("FAIL lw_4_nowrite_const: got %h want 80010000", r); end
      do_req(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, "lw_10_nowrite", r, e);
      tests_run++;
      if (r !== 32'h0) begin tests_failed++; $display("FAIL lw_10_nowrite_const: got %h want 00000000", r); end
   endtask

   task automatic test_latency3();
      logic [31:0] r;
      logic e;
      int n;
      do_req(1, 1'b1, 32'hC, 2'd2, 1'b0, 32'hA5A5_0F0F, "l3_sw_c", r, e);
      n = 0;
      @(negedge clk);
      while (ready3 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      // Hold req_valid across the busy window: the second accept lands four edges later.
      req_write = 1'b0; req_addr = 32'hC; req_size = 2'd2; req_unsigned = 1'b0;
      req_valid3 = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         tests_run++;
         if (ready3 !== (k == 4) || rv3 !== (k == 3)) begin
            tests_failed++;
            $display("FAIL l3_window_k%0d: ready %b valid %b want %b %b", k, ready3, rv3, (k == 4), (k == 3));
         end
      end
      @(posedge clk);
      #1;
      req_valid3 = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         tests_run++;
         if (rv3 !== (k == 3) || ready3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL l3_second_k%0d: valid %b ready %b want %b 0", k, rv3, ready3, (k == 3));
         end
      end
      tests_run++;
      if (rdata3 !== 32'hA5A5_0F0F || err3 !== 1'b0) begin
         tests_failed++;
         $display("FAIL l3_second_data: got %h err %b want a5a50f0f err 0", rdata3, err3);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] r;
      logic e;
      int pulses;
      int n;
      n = 0;
      @(negedge clk);
      while (ready3 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      req_write = 1'b1; req_addr = 32'h4; req_size = 2'd2; req_wdata = 32'h1234_5678;
      req_valid3 = 1'b1;
      @(posedge clk);
      #1;
      req_valid3 = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests_run++;
      if (rv3 !== 1'b0 || ready3 !== 1'b0 || busy3 !== 1'b1) begin
         tests_failed++;
         $display("FAIL midwait_reset: valid %b ready %b busy %b want 0 0 1", rv3, ready3, busy3);
      end
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rv3 === 1'b1 || rv1 === 1'b1) pulses++;
      end
      tests_run++;
      if (pulses != 0 || ready3 !== 1'b1) begin
         tests_failed++;
         $display("FAIL midwait_no_pulse: pulses %0d ready %b want 0 1", pulses, ready3);
      end
      clear_model();
      do_req(1, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, "resweep_lw_4", r, e);
      tests_run++;
      if (r !== 32'h0) begin tests_failed++; $display("FAIL resweep_const: got %h want 00000000", r); end
      do_req(0, 1'b1, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, "alias_sw_0", r, e);
      do_req(0, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, "alias_lw_40", r, e);
      tests_run++;
      if (r !== 32'hCAFE_F00D || e !== 1'b0) begin
         tests_failed++;
         $display("FAIL alias_const: got %h err %b want cafef00d err 0", r, e);
      end
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic e;
      logic [1:0] sz;
      for (int i = 0; i < 80; i++) begin
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         do_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                sz, 1'($urandom_range(0, 1)), $urandom, "random", r, e);
      end
   endtask

   initial begin
      test_reset();
      test_byte_word();
      test_half();
      test_misaligned();
      test_latency3();
      test_reset_mid_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
